// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame field layout,
// common to the transmitter and receiver.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

    // Frame layout: bit0 start (0), bits8:1 data, bit9 stop (1)
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DATA_BITS-1:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with mid-bit and end-of-period ticks. The counter wraps
// at CLKS_PER_BIT-1; clear restarts it so the caller can align it to an edge.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic t_clk,
    input  logic reset,
    input  logic clear,
    output logic mid_tick,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear || count_reg == LAST) begin
            count_next = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge t_clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign mid_tick = (count_reg == MID);
    assign bit_tick = (count_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a single-entry holding register
// with valid/ready handoff, stop-bit error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  r_clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  rx_ready,
    output logic                  rx_valid,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic [FRAME_BITS-1:0] rx_frame,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun
);

    uart_rx_state_t state_reg, state_next;

    logic [1:0]           sync_reg;
    logic                 rx_sync;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 cnt_clear;
    logic                 mid_tick;
    logic                 bit_tick;
    logic                 data_sample;
    logic                 frame_done;
    logic                 stop_bad;

    logic                  valid_reg;
    logic [DATA_BITS-1:0]  data_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic                  frame_err_reg;
    logic                  overrun_reg;

    // Synchronizer resets to the idle (high) line level
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
        end
    end

    assign rx_sync = sync_reg[1];

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .t_clk   (r_clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .mid_tick(mid_tick),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
        end
    end

    // Counter is cleared at the start-bit centre, so later centres fall on bit_tick
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        cnt_clear    = 1'b0;
        data_sample  = 1'b0;
        frame_done   = 1'b0;
        stop_bad     = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                if (!rx_sync) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_tick) begin
                    cnt_clear = 1'b1;
                    if (!rx_sync) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_tick) begin
                    data_sample = 1'b1;
                    if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (rx_sync) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_clear = 1'b1;
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            always_ff @(posedge r_clk or posedge reset) begin
                if (reset) begin
                    shift_reg[gi] <= 1'b0;
                end else if (data_sample && bit_idx_reg == 3'(gi)) begin
                    shift_reg[gi] <= rx_sync;
                end
            end
        end
    endgenerate

    // Completion always loads; overrun only when the held frame was not taken this cycle
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            frame_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= stop_bad;
            if (frame_done) begin
                valid_reg <= 1'b1;
                data_reg  <= shift_reg;
                frame_reg <= make_frame(shift_reg);
                if (valid_reg && !rx_ready) begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && rx_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rx_valid  = valid_reg;
    assign rx_data   = data_reg;
    assign rx_frame  = frame_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed/randomized bench for uart_rx: drives 8N1 frames on the line and
// checks outputs against expectations derived from the bytes sent.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       r_clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [9:0] rx_frame;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .r_clk    (r_clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rx_ready (rx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_frame (rx_frame),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  frame;
        int unsigned cyc;
    } rec_t;

    rec_t        rec_q[$];
    int unsigned cyc = 0;
    int unsigned valid_cycles = 0;
    int unsigned ferr_cycles = 0;
    logic        prev_valid = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;

    // Observer: logs each rising edge of rx_valid and counts high cycles
    always @(negedge r_clk) begin
        cyc <= cyc + 1;
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (frame_err) ferr_cycles <= ferr_cycles + 1;
        if (rx_valid && !prev_valid) rec_q.push_back('{rx_data, rx_frame, cyc + 1});
        prev_valid <= rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic line(input logic v, input int n);
        rx_in = v;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(d[i], CPB);
        line(stop_v, CPB);
    endtask

    // Expected frame from the wire format: start 0 at bit0, data, stop 1 at bit9
    task automatic expect_frame(input logic [7:0] d, input int unsigned t0, input string tag);
        int          b = 0;
        rec_t        r;
        logic [9:0]  ef;
        int unsigned lat;
        while (rec_q.size() == 0 && b < 4 * CPB) begin
            tick(1);
            b++;
        end
        check({tag, "_seen"}, 16'(rec_q.size() != 0), 16'd1);
        if (rec_q.size() != 0) begin
            r   = rec_q.pop_front();
            ef  = 10'h200 | (10'(d) << 1);
            lat = r.cyc - t0;
            check({tag, "_data"}, 16'(r.data), 16'(d));
            check({tag, "_frame"}, 16'(r.frame), 16'(ef));
            // 2 sync flops + 9.5 bit periods, within one cycle of edge alignment
            check({tag, "_latency_ok"}, 16'(lat >= 154 && lat <= 156), 16'd1);
            $display("frame %s data=%02h frame=%03h latency=%0d", tag, r.data, r.frame, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bytes[5];
        int unsigned t0, t1, vc0, fe0;

        tick(3);
        check("rst_valid", 16'(rx_valid), 16'd0);
        check("rst_data", 16'(rx_data), 16'd0);
        check("rst_frame", 16'(rx_frame), 16'd0);
        check("rst_ferr", 16'(frame_err), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        check("rst_busy", 16'(rx_busy), 16'd0);
        reset = 1'b0;
        tick(5);

        bytes[0] = 8'hA5;
        for (int i = 1; i < 5; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) begin
            t0  = cyc;
            vc0 = valid_cycles;
            fe0 = ferr_cycles;
            send_frame(bytes[i], 1'b1);
            tick(CPB);
            expect_frame(bytes[i], t0, $sformatf("rand%0d", i));
            check("one_cycle_valid", 16'(valid_cycles - vc0), 16'd1);
            check("no_ferr", 16'(ferr_cycles - fe0), 16'd0);
            if (i == 0) check("a5_frame_const", 16'(rx_frame), 16'h34A);
        end

        fe0 = ferr_cycles;
        line(1'b0, 5);
        rx_in = 1'b1;
        check("glitch_busy_during", 16'(rx_busy), 16'd1);
        tick(10);
        check("glitch_busy_after", 16'(rx_busy), 16'd0);
        check("glitch_no_frame", 16'(rec_q.size()), 16'd0);
        check("glitch_no_ferr", 16'(ferr_cycles - fe0), 16'd0);
        $display("glitch 5 cycles busy=%0b", rx_busy);

        fe0 = ferr_cycles;
        vc0 = valid_cycles;
        send_frame(8'h3C, 1'b0);
        tick(CPB);
        check("brk_ferr_one_pulse", 16'(ferr_cycles - fe0), 16'd1);
        check("brk_no_valid", 16'(valid_cycles - vc0), 16'd0);
        check("brk_busy_low_line", 16'(rx_busy), 16'd1);
        rx_in = 1'b1;
        tick(5);
        check("brk_busy_released", 16'(rx_busy), 16'd0);
        $display("break 3C ferr_cycles=%0d busy=%0b", ferr_cycles - fe0, rx_busy);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(CPB);
        send_frame(8'h22, 1'b1);
        tick(CPB);
        check("ovr_valid", 16'(rx_valid), 16'd1);
        check("ovr_data", 16'(rx_data), 16'h22);
        check("ovr_frame", 16'(rx_frame), 16'(10'h200 | (10'h22 << 1)));
        check("ovr_flag", 16'(overrun), 16'd1);
        check("ovr_one_rise", 16'(rec_q.size()), 16'd1);
        if (rec_q.size() != 0) check("ovr_first_data", 16'(rec_q.pop_front().data), 16'h11);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_valid_drop", 16'(rx_valid), 16'd0);
        check("ovr_sticky", 16'(overrun), 16'd1);
        $display("overrun 11/22 data=%02h overrun=%0b", rx_data, overrun);

        rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        tick(CPB);
        while (rec_q.size() != 0) void'(rec_q.pop_front());
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(1'b1, CPB);
        line(1'b1, CPB / 2);
        check("pre_rst_valid", 16'(rx_valid), 16'd1);
        check("pre_rst_busy", 16'(rx_busy), 16'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 16'(rx_valid), 16'd0);
        check("mid_rst_data", 16'(rx_data), 16'd0);
        check("mid_rst_frame", 16'(rx_frame), 16'd0);
        check("mid_rst_ferr", 16'(frame_err), 16'd0);
        check("mid_rst_overrun", 16'(overrun), 16'd0);
        check("mid_rst_busy", 16'(rx_busy), 16'd0);
        $display("reset during FF bit4 valid=%0b overrun=%0b busy=%0b", rx_valid, overrun, rx_busy);
        tick(2);
        reset = 1'b0;
        tick(CPB);
        rx_ready = 1'b1;
        t0 = cyc;
        send_frame(8'h0F, 1'b1);
        tick(CPB);
        expect_frame(8'h0F, t0, "after_rst");

        fe0 = ferr_cycles;
        t0  = cyc;
        send_frame(8'h00, 1'b1);
        t1  = cyc;
        send_frame(8'hFF, 1'b1);
        tick(CPB);
        expect_frame(8'h00, t0, "b2b0");
        expect_frame(8'hFF, t1, "b2b1");
        check("b2b_no_ferr", 16'(ferr_cycles - fe0), 16'd0);
        check("b2b_no_overrun", 16'(overrun), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: r_clk cycles per bit period, legal range 4..1023, even.
REQ-002 SHALL have port r_clk, input, 1, single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-005 SHALL have port rx_ready, input, 1, consumer accepts held frame when high with rx_valid.
REQ-006 SHALL have port rx_valid, output, 1, held frame available.
REQ-007 SHALL have port rx_data, output, 8, received data byte, LSB first on line.
REQ-008 SHALL have port rx_frame, output, 10, full frame: bit0 start, bits8:1 data, bit9 stop; matches the transmitter's data_in layout.
REQ-009 SHALL have port rx_busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1, sticky flag; a frame completed while rx_valid was high; cleared only by reset.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized bit.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on synchronized 0, SHALL clear the bit-period counter and go to START.
REQ-015 START: at counter = CLKS_PER_BIT/2-1 (mid-bit) SHALL resample; 0 -> DATA with counter cleared, bit index 0; 1 -> IDLE (glitch, no flags).
REQ-016 DATA: SHALL sample once per CLKS_PER_BIT cycles at mid-bit, shift into bit (index), after index 7 go to STOP.
REQ-017 STOP: at mid-bit sample 1 SHALL load rx_data/rx_frame and set rx_valid on the next edge, return to IDLE.
REQ-018 STOP: at mid-bit sample 0 SHALL pulse frame_err one cycle, not update rx_data/rx_frame/rx_valid, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL remain until synchronized line is 1, then IDLE (break handling).
REQ-020 Latency: rx_valid SHALL rise exactly 1 cycle after the stop-bit mid-sample edge; line-to-valid = sync 2 + 9.5 bit periods.
REQ-021 rx_valid SHALL stay high, rx_data/rx_frame stable, until a cycle with rx_valid and rx_ready both high; rx_valid low the next cycle.
REQ-022 Simultaneous accept and new frame completion in the same cycle: new frame SHALL load, rx_valid SHALL stay high, overrun SHALL NOT set.
REQ-023 Frame completion with rx_valid high and no accept: new frame SHALL overwrite held frame, overrun SHALL set.
REQ-024 Counter SHALL be clog2(CLKS_PER_BIT) bits and wrap to 0 at CLKS_PER_BIT-1; bit index 3 bits.
REQ-025 rx_ready SHALL NOT affect line sampling; receiver never stalls.

Reset
REQ-026 Reset asserted SHALL immediately force: state IDLE, counters 0, synchronizer 1s, rx_valid 0, rx_data 0, rx_frame 0, frame_err 0, overrun 0, rx_busy 0.
REQ-027 Reset mid-frame SHALL discard partial frame; after release, a line already low SHALL be treated as a new start bit.

Structure
REQ-028 State enum (uart_rx_state_t) and frame field widths (DATA_BITS=8, FRAME_BITS=10) SHALL live in shared package uart_pkg, shared with the transmitter.
REQ-029 Bit-period counter plus mid-bit tick generation SHALL be one sub-module, uart_baud_tick; all else in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-030 Send 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, rx_frame=10'h34A, frame_err=0.
REQ-031 Low glitch of 5 cycles on idle line -> no rx_valid, no frame_err, back to IDLE, rx_busy low within 10 cycles.
REQ-032 Send 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid 0, rx_busy high until line returns high.
REQ-033 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x22, overrun=1; raise rx_ready -> rx_valid drops next cycle, overrun stays 1.
REQ-034 Assert reset during DATA bit 4 of 0xFF -> all outputs 0 immediately; next full 0x0F frame received correctly.
REQ-035 Back-to-back 0x00 and 0xFF with no idle gap -> both received in order, no errors.
